// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller: FSM states, derived
// address-field widths and the line-address construction helper.
package cache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_BUF,
    ST_WB_REQ,
    ST_WB_DATA,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_DONE
  } refill_state_e;

  // Byte offset within a line: word select plus 2 byte-select bits.
  function automatic int unsigned calc_offset_w(input int unsigned line_words);
    return 32'($clog2(line_words)) + 32'd2;
  endfunction

  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned index_w,
                                             input int unsigned line_words);
    return addr_w - index_w - calc_offset_w(line_words);
  endfunction

  // {tag, index, zero offset}; caller truncates to its address width.
  function automatic logic [63:0] line_addr(input logic [63:0]   tag,
                                            input logic [63:0]   index,
                                            input int unsigned   index_w,
                                            input int unsigned   offset_w);
    return (tag << (index_w + offset_w)) | (index << offset_w);
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_line_buf.sv
// Victim line buffer: holds one cache line read out of the data array while
// it waits to be streamed to memory. Contents are not reset.
//   clk      clock
//   we_i     write enable, waddr_i / wdata_i write port
//   raddr_i  combinational read index, rdata_o read data
module refill_line_buf
  import cache_refill_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned DATA_W     = 32,
  localparam int unsigned WORD_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [WORD_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [LINE_WORDS];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller for a 2-way set-associative cache.
// Accepts a miss, writes back the tracker-selected victim if valid and dirty,
// refills the line from memory (word 0 first), writes the new tag and reports
// the filled way to the replacement tracker.
//   miss_*        miss request from the pipeline, victim info sampled on accept
//   arr_*         data array read/write port (read data one cycle after arr_re)
//   tag_*         tag array write (new line valid, clean)
//   mem_req_*     memory line request (write = writeback, read = refill)
//   mem_w*        writeback beats, mem_r* refill beats
//   lru_*         fill report to the tracker, refill_done completion pulse
//   proto_err     sticky: mem_rlast disagreed with the beat count
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned INDEX_W    = 7,
  localparam int unsigned OFFSET_W   = calc_offset_w(LINE_WORDS),
  localparam int unsigned TAG_W      = calc_tag_w(ADDR_W, INDEX_W, LINE_WORDS),
  localparam int unsigned WORD_W     = $clog2(LINE_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [ADDR_W-1:0]  miss_addr,
  input  logic               lru_replace,
  input  logic               victim_valid,
  input  logic               victim_dirty,
  input  logic [TAG_W-1:0]   victim_tag,
  output logic               arr_re,
  output logic               arr_we,
  output logic               arr_way,
  output logic [INDEX_W-1:0] arr_index,
  output logic [WORD_W-1:0]  arr_word,
  output logic [DATA_W-1:0]  arr_wdata,
  input  logic [DATA_W-1:0]  arr_rdata,
  output logic               tag_we,
  output logic               tag_way,
  output logic [INDEX_W-1:0] tag_index,
  output logic [TAG_W-1:0]   tag_wdata,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_write,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic               mem_wvalid,
  input  logic               mem_wready,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_wlast,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_rlast,
  output logic               lru_enable,
  output logic               lru_target,
  output logic               refill_done,
  output logic               proto_err
);

  localparam int unsigned      CNT_W     = WORD_W + 1;
  localparam logic [CNT_W-1:0] CNT_LINE  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LASTW = CNT_W'(LINE_WORDS - 1);

  refill_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               way_q, way_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   mtag_q, mtag_d;
  logic [TAG_W-1:0]   vtag_q, vtag_d;
  logic               perr_q, perr_d;

  logic               buf_we;
  logic [WORD_W-1:0]  buf_waddr;
  logic [WORD_W-1:0]  buf_raddr;
  logic [DATA_W-1:0]  buf_rdata;

  logic [ADDR_W-1:0]  wb_addr;
  logic [ADDR_W-1:0]  rd_addr;

  // Byte/word offset of the miss address is irrelevant: fills are whole lines.
  logic unused_offset;
  assign unused_offset = ^miss_addr[OFFSET_W-1:0];

  assign wb_addr   = ADDR_W'(line_addr(64'(vtag_q), 64'(index_q), INDEX_W, OFFSET_W));
  assign rd_addr   = ADDR_W'(line_addr(64'(mtag_q), 64'(index_q), INDEX_W, OFFSET_W));
  assign proto_err = perr_q;

  refill_line_buf #(
    .LINE_WORDS(LINE_WORDS),
    .DATA_W    (DATA_W)
  ) u_line_buf (
    .clk    (clk),
    .we_i   (buf_we),
    .waddr_i(buf_waddr),
    .wdata_i(arr_rdata),
    .raddr_i(buf_raddr),
    .rdata_o(buf_rdata)
  );

  // State and context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      way_q   <= 1'b0;
      index_q <= '0;
      mtag_q  <= '0;
      vtag_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
      index_q <= index_d;
      mtag_q  <= mtag_d;
      vtag_q  <= vtag_d;
      perr_q  <= perr_d;
    end
  end

  // Next state, counter and output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    way_d         = way_q;
    index_d       = index_q;
    mtag_d        = mtag_q;
    vtag_d        = vtag_q;
    perr_d        = perr_q;
    miss_ready    = 1'b0;
    arr_re        = 1'b0;
    arr_we        = 1'b0;
    arr_way       = 1'b0;
    arr_index     = '0;
    arr_word      = '0;
    arr_wdata     = '0;
    tag_we        = 1'b0;
    tag_way       = 1'b0;
    tag_index     = '0;
    tag_wdata     = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    mem_wlast     = 1'b0;
    lru_enable    = 1'b0;
    lru_target    = 1'b0;
    refill_done   = 1'b0;
    buf_we        = 1'b0;
    buf_waddr     = '0;
    buf_raddr     = '0;

    unique case (state_q)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          way_d   = lru_replace;
          index_d = miss_addr[OFFSET_W +: INDEX_W];
          mtag_d  = miss_addr[ADDR_W-1 -: TAG_W];
          vtag_d  = victim_tag;
          cnt_d   = '0;
          state_d = (victim_valid && victim_dirty) ? ST_WB_BUF : ST_RD_REQ;
        end
      end

      // Reads issue on counts 0..N-1; each lands in the buffer one count later.
      ST_WB_BUF: begin
        if (cnt_q < CNT_LINE) begin
          arr_re    = 1'b1;
          arr_way   = way_q;
          arr_index = index_q;
          arr_word  = cnt_q[WORD_W-1:0];
        end
        if (cnt_q != '0) begin
          buf_we    = 1'b1;
          buf_waddr = WORD_W'(cnt_q - CNT_W'(1));
        end
        if (cnt_q == CNT_LINE) begin
          cnt_d   = '0;
          state_d = ST_WB_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = wb_addr;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WB_DATA;
        end
      end

      ST_WB_DATA: begin
        mem_wvalid = 1'b1;
        buf_raddr  = cnt_q[WORD_W-1:0];
        mem_wdata  = buf_rdata;
        mem_wlast  = (cnt_q == CNT_LASTW);
        if (mem_wready) begin
          if (cnt_q == CNT_LASTW) begin
            cnt_d   = '0;
            state_d = ST_RD_REQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = rd_addr;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_RD_DATA;
        end
      end

      // Beat count decides completion; rlast is only cross-checked.
      ST_RD_DATA: begin
        if (mem_rvalid) begin
          arr_we    = 1'b1;
          arr_way   = way_q;
          arr_index = index_q;
          arr_word  = cnt_q[WORD_W-1:0];
          arr_wdata = mem_rdata;
          if (mem_rlast != (cnt_q == CNT_LASTW)) begin
            perr_d = 1'b1;
          end
          if (cnt_q == CNT_LASTW) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        tag_we      = 1'b1;
        tag_way     = way_q;
        tag_index   = index_q;
        tag_wdata   = mtag_q;
        lru_enable  = 1'b1;
        lru_target  = way_q;
        refill_done = 1'b1;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: transaction-level expectation
// queue per miss, per-cycle protocol invariants, responsive array/memory model.
module tb_cache_refill_ctrl;

  localparam int LW = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        miss_valid, miss_ready;
  logic [31:0] miss_addr;
  logic        lru_replace, victim_valid, victim_dirty;
  logic [20:0] victim_tag;
  logic        arr_re, arr_we, arr_way;
  logic [6:0]  arr_index;
  logic [1:0]  arr_word;
  logic [31:0] arr_wdata, arr_rdata;
  logic        tag_we, tag_way;
  logic [6:0]  tag_index;
  logic [20:0] tag_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr;
  logic        mem_wvalid, mem_wready, mem_wlast;
  logic [31:0] mem_wdata;
  logic        mem_rvalid, mem_rlast;
  logic [31:0] mem_rdata;
  logic        lru_enable, lru_target, refill_done, proto_err;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .lru_replace(lru_replace), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .arr_re(arr_re), .arr_we(arr_we), .arr_way(arr_way), .arr_index(arr_index),
    .arr_word(arr_word), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .tag_we(tag_we), .tag_way(tag_way), .tag_index(tag_index), .tag_wdata(tag_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wlast(mem_wlast), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .lru_enable(lru_enable), .lru_target(lru_target),
    .refill_done(refill_done), .proto_err(proto_err)
  );

  typedef enum int {EV_ARE, EV_WREQ, EV_RREQ, EV_WB, EV_AWE, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] a;
    logic [31:0] d;
    logic        b;
  } ev_t;

  ev_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // model / responder state
  bit          busy, perr_m, pend_rd, prev_req, prev_wv, prev_req_w, prev_wlast;
  bit          accepted, done_seen, seen_wv;
  logic [31:0] pend_val, prev_req_addr, prev_wdata, rd_line, last_rreq, last_wreq;
  int          rd_left, rd_beat, stall_left, n_awe, n_accepts;
  // stimulus knobs
  int          ready_pct, wready_pct, rvalid_pct, req_stall, bad_beat;
  bit          q_valid, q_lru, q_vv, q_vd;
  logic [31:0] q_addr;
  logic [20:0] q_vtag;

  function automatic logic [31:0] ahash(input logic way, input logic [6:0] idx, input logic [1:0] w);
    return ({22'd0, way, idx, w} * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic logic [31:0] mhash(input logic [31:0] line, input int beat);
    return ((line + 32'(beat)) * 32'h85EBCA6B) ^ 32'h01234567;
  endfunction

  function automatic logic [31:0] wix(input logic way, input logic [6:0] idx, input logic [1:0] w);
    return {22'd0, way, idx, w};
  endfunction

  function automatic logic [71:0] evbits(input ev_t e);
    return {3'd0, 4'(e.kind), e.a, e.d, e.b};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int budget);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no completion within %0d cycles", name, budget);
  endtask

  // Expected transaction sequence for one accepted miss.
  task automatic build_expect();
    logic [6:0]  idx;
    logic        way;
    logic [31:0] line;
    idx  = miss_addr[10:4];
    way  = lru_replace;
    line = {miss_addr[31:4], 4'b0};
    if (victim_valid && victim_dirty) begin
      for (int w = 0; w < LW; w++) exp_q.push_back('{EV_ARE, wix(way, idx, 2'(w)), 32'd0, 1'b0});
      exp_q.push_back('{EV_WREQ, {victim_tag, idx, 4'b0}, 32'd0, 1'b0});
      for (int w = 0; w < LW; w++) exp_q.push_back('{EV_WB, 32'd0, ahash(way, idx, 2'(w)), w == LW - 1});
    end
    exp_q.push_back('{EV_RREQ, line, 32'd0, 1'b0});
    for (int w = 0; w < LW; w++) exp_q.push_back('{EV_AWE, wix(way, idx, 2'(w)), mhash(line, w), 1'b0});
    exp_q.push_back('{EV_DONE, {20'd0, 3'b111, way, way, idx}, {11'd0, miss_addr[31:11]}, 1'b0});
  endtask

  // One clock: drive inputs at negedge, check settled outputs, record handshakes.
  task automatic step();
    ev_t obs[$];
    ev_t e;
    @(negedge clk);
    miss_valid   = q_valid;
    miss_addr    = q_addr;
    lru_replace  = q_lru;
    victim_valid = q_vv;
    victim_dirty = q_vd;
    victim_tag   = q_vtag;
    arr_rdata    = pend_rd ? pend_val : $urandom();
    pend_rd      = 1'b0;
    if (mem_req_valid && stall_left > 0) begin
      mem_req_ready = 1'b0;
      stall_left--;
    end else begin
      mem_req_ready = ($urandom_range(0, 99) < ready_pct);
    end
    mem_wready = ($urandom_range(0, 99) < wready_pct);
    if (rd_left > 0 && $urandom_range(0, 99) < rvalid_pct) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mhash(rd_line, rd_beat);
      mem_rlast  = (rd_beat == LW - 1) ^ (rd_beat == bad_beat);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom();
      mem_rlast  = 1'($urandom_range(0, 1));
    end
    #1;
    accepted  = 1'b0;
    done_seen = 1'b0;

    check("miss_ready", 72'(miss_ready), 72'(!busy));
    check("proto_err", 72'(proto_err), 72'(perr_m));
    if (!busy)
      check("idle_quiet", 72'({arr_re, arr_we, tag_we, mem_req_valid, mem_wvalid, lru_enable, refill_done}), 72'd0);
    if (prev_req)
      check("req_stable", 72'({mem_req_valid, mem_req_write, mem_req_addr}), 72'({1'b1, prev_req_w, prev_req_addr}));
    if (prev_wv)
      check("wbeat_stable", 72'({mem_wvalid, mem_wlast, mem_wdata}), 72'({1'b1, prev_wlast, prev_wdata}));
    prev_req      = mem_req_valid && !mem_req_ready;
    prev_req_w    = mem_req_write;
    prev_req_addr = mem_req_addr;
    prev_wv       = mem_wvalid && !mem_wready;
    prev_wlast    = mem_wlast;
    prev_wdata    = mem_wdata;

    if (arr_re) begin
      obs.push_back('{EV_ARE, wix(arr_way, arr_index, arr_word), 32'd0, 1'b0});
      pend_rd  = 1'b1;
      pend_val = ahash(arr_way, arr_index, arr_word);
    end
    if (mem_req_valid && mem_req_ready) begin
      obs.push_back('{mem_req_write ? EV_WREQ : EV_RREQ, mem_req_addr, 32'd0, 1'b0});
      stall_left = req_stall;
      if (mem_req_write) begin
        last_wreq = mem_req_addr;
      end else begin
        last_rreq = mem_req_addr;
        rd_line   = mem_req_addr;
        rd_left   = LW;
        rd_beat   = 0;
      end
    end
    if (mem_wvalid) seen_wv = 1'b1;
    if (mem_wvalid && mem_wready) obs.push_back('{EV_WB, 32'd0, mem_wdata, mem_wlast});
    if (arr_we) begin
      obs.push_back('{EV_AWE, wix(arr_way, arr_index, arr_word), arr_wdata, 1'b0});
      n_awe++;
    end
    if (mem_rvalid) begin
      if (mem_rlast != (rd_beat == LW - 1)) perr_m = 1'b1;
      rd_beat++;
      rd_left--;
    end
    if (refill_done || lru_enable || tag_we) begin
      obs.push_back('{EV_DONE, {20'd0, tag_we, lru_enable, refill_done, lru_target, tag_way, tag_index},
                      {11'd0, tag_wdata}, 1'b0});
      done_seen = 1'b1;
      busy      = 1'b0;
    end

    foreach (obs[i]) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d a=%h d=%h, required no event",
                 obs[i].kind, obs[i].a, obs[i].d);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("event_kind%0d", e.kind), evbits(obs[i]), evbits(e));
      end
    end
    if (done_seen) check("events_drained", 72'(exp_q.size()), 72'd0);

    if (miss_valid && miss_ready) begin
      accepted = 1'b1;
      n_accepts++;
      busy       = 1'b1;
      stall_left = req_stall;
      build_expect();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    miss_valid = 1'b0; mem_req_ready = 1'b0; mem_wready = 1'b0;
    mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0; arr_rdata = '0;
    q_valid = 1'b0;
    #1;
    check("rst_miss_ready", 72'(miss_ready), 72'd1);
    check("rst_outputs_zero", 72'(|{arr_re, arr_we, arr_way, arr_index, arr_word, arr_wdata,
          tag_we, tag_way, tag_index, tag_wdata, mem_req_valid, mem_req_write, mem_req_addr,
          mem_wvalid, mem_wdata, mem_wlast, lru_enable, lru_target, refill_done, proto_err}), 72'd0);
    exp_q.delete();
    busy = 0; perr_m = 0; pend_rd = 0; prev_req = 0; prev_wv = 0;
    rd_left = 0; rd_beat = 0; stall_left = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 4000);
    if (!accepted) timeout(name, 4000);
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!done_seen && lat < 4000);
    if (!done_seen) timeout(name, 4000);
  endtask

  task automatic set_miss(input logic [31:0] addr, input bit lru, input bit vv, input bit vd,
                          input logic [20:0] vtag);
    q_addr = addr; q_lru = lru; q_vv = vv; q_vd = vd; q_vtag = vtag;
  endtask

  task automatic run_miss(input logic [31:0] addr, input bit lru, input bit vv, input bit vd,
                          input logic [20:0] vtag, output int lat);
    set_miss(addr, lru, vv, vd, vtag);
    q_valid = 1'b1;
    wait_accept("accept");
    q_valid = 1'b0;
    wait_done("done", lat);
  endtask

  initial begin
    int lat;
    int acc0;
    rst = 1'b0;
    q_valid = 0; q_addr = '0; q_lru = 0; q_vv = 0; q_vd = 0; q_vtag = '0;
    miss_valid = 0; miss_addr = '0; lru_replace = 0; victim_valid = 0; victim_dirty = 0;
    victim_tag = '0;
    ready_pct = 100; wready_pct = 100; rvalid_pct = 100; req_stall = 0; bad_beat = -1;
    n_awe = 0; n_accepts = 0; last_rreq = '0; last_wreq = '0; seen_wv = 0;
    do_reset();

    // clean victim, zero-wait memory
    run_miss(32'h0000_1230, 1'b1, 1'b1, 1'b0, 21'h0, lat);
    check("clean_latency", 72'(lat), 72'd6);
    check("clean_rd_addr", 72'(last_rreq), 72'h1230);
    check("clean_no_wreq", 72'(last_wreq), 72'd0);

    // dirty victim
    run_miss(32'h0000_1230, 1'b0, 1'b1, 1'b1, 21'h1ABCD, lat);
    check("dirty_latency", 72'(lat), 72'd16);
    check("dirty_wb_addr", 72'(last_wreq), 72'h0D5E_6A30);

    // dirty bit without valid: no writeback
    last_wreq = '0;
    run_miss(32'h0000_4560, 1'b1, 1'b0, 1'b1, 21'h05555, lat);
    check("invalid_victim_latency", 72'(lat), 72'd6);
    check("invalid_victim_no_wreq", 72'(last_wreq), 72'd0);

    // backpressure on request, writeback and refill channels
    req_stall = 5; wready_pct = 50; rvalid_pct = 60;
    run_miss(32'hDEAD_BEE0, 1'b1, 1'b1, 1'b1, 21'h1F0F0, lat);
    check("stall_no_early_done", 72'(lat > 26), 72'd1);

    // early rlast on beat 1
    req_stall = 0; wready_pct = 100; rvalid_pct = 100; bad_beat = 1; n_awe = 0;
    run_miss(32'h0000_2000, 1'b0, 1'b1, 1'b0, 21'h0, lat);
    bad_beat = -1;
    check("rlast_proto_err", 72'(proto_err), 72'd1);
    check("rlast_four_beats", 72'(n_awe), 72'd4);
    run_miss(32'h0001_0040, 1'b1, 1'b0, 1'b0, 21'h0, lat);
    check("proto_err_sticky", 72'(proto_err), 72'd1);

    // reset while streaming writeback data
    wready_pct = 20; seen_wv = 0;
    set_miss(32'h0ABC_0070, 1'b1, 1'b1, 1'b1, 21'h00777);
    q_valid = 1'b1;
    wait_accept("wb_accept");
    q_valid = 1'b0;
    lat = 0;
    while (!seen_wv && lat < 4000) begin
      step();
      lat++;
    end
    if (!seen_wv) timeout("reach_wb_data", 4000);
    step();
    do_reset();
    wready_pct = 100;
    run_miss(32'h0000_0F00, 1'b0, 1'b1, 1'b0, 21'h0, lat);
    check("post_reset_latency", 72'(lat), 72'd6);

    // miss held across a refill: accepted once, the cycle after DONE
    acc0 = n_accepts;
    set_miss(32'h1234_5670, 1'b1, 1'b1, 1'b1, 21'h00ABC);
    q_valid = 1'b1;
    wait_accept("held_first");
    set_miss(32'h0000_8880, 1'b0, 1'b1, 1'b0, 21'h0);
    wait_done("held_first_done", lat);
    check("held_single_accept", 72'(n_accepts - acc0), 72'd1);
    step();
    check("held_second_accept", 72'(accepted), 72'd1);
    q_valid = 1'b0;
    wait_done("held_second_done", lat);
    check("held_total_accepts", 72'(n_accepts - acc0), 72'd2);

    // randomized misses and memory timing
    for (int i = 0; i < 40; i++) begin
      ready_pct  = $urandom_range(30, 100);
      wready_pct = $urandom_range(30, 100);
      rvalid_pct = $urandom_range(30, 100);
      req_stall  = $urandom_range(0, 5);
      bad_beat   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, LW - 1) : -1;
      run_miss($urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 21'($urandom()), lat);
    end
    bad_beat = -1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Consumer end of the replacement-tracker interface for the 2-way set-associative cache.
- On a miss, samples the tracker's victim way and writes back the victim line if it is dirty.
- Refills the line from memory into that way, updates the tag, then reports the filled way back to the tracker (enable/target pulse).
- Sits between the cache pipeline's miss path, the data/tag arrays and the memory bus.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, bus/array word width
- LINE_WORDS, 4, words per line (power of 2, >=2)
- INDEX_W, 7, set index width; OFFSET_W = log2(LINE_WORDS)+2, TAG_W = ADDR_W-INDEX_W-OFFSET_W (derived)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- miss_valid  in  1  miss request
- miss_ready  out  1  high only in IDLE
- miss_addr  in  ADDR_W  missing address
- lru_replace  in  1  victim way from tracker, sampled on miss accept
- victim_valid  in  1  victim line valid, sampled on accept
- victim_dirty  in  1  victim line dirty, sampled on accept
- victim_tag  in  TAG_W  victim tag, sampled on accept
- arr_re  out  1  data array read enable
- arr_we  out  1  data array write enable
- arr_way  out  1  selected way
- arr_index  out  INDEX_W  set index
- arr_word  out  log2(LINE_WORDS)  word within line
- arr_wdata  out  DATA_W  refill data
- arr_rdata  in  DATA_W  read data, valid 1 cycle after arr_re
- tag_we  out  1  tag write: valid=1, dirty=0
- tag_way  out  1  way for tag write
- tag_index  out  INDEX_W  index for tag write
- tag_wdata  out  TAG_W  new tag
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accepted
- mem_req_write  out  1  1 = writeback, 0 = read
- mem_req_addr  out  ADDR_W  line-aligned address
- mem_wvalid  out  1  writeback beat valid
- mem_wready  in  1  writeback beat accepted
- mem_wdata  out  DATA_W  writeback beat data
- mem_wlast  out  1  last writeback beat
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  DATA_W  refill beat data
- mem_rlast  in  1  last refill beat
- lru_enable  out  1  one-cycle pulse to tracker
- lru_target  out  1  way just filled
- refill_done  out  1  one-cycle completion pulse
- proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except miss_ready=1. Counters 0, proto_err 0. Reset mid-operation abandons the transfer; the victim buffer contents are don't-care.
- IDLE: accepts the miss when miss_valid & miss_ready. Latches way=lru_replace, index, miss tag, victim_tag. Next state is WB_BUF if victim_valid & victim_dirty, else RD_REQ.
- WB_BUF: issues arr_re for words 0..LINE_WORDS-1 on consecutive cycles. Captures arr_rdata one cycle later into a LINE_WORDS-entry buffer. Goes to WB_REQ after LINE_WORDS+1 cycles.
- WB_REQ: mem_req_valid=1, write=1, addr={victim_tag,index,0}. Holds all request fields stable until mem_req_ready, then goes to WB_DATA.
- WB_DATA: streams buffer words 0..LINE_WORDS-1. mem_wvalid held high and data held stable until mem_wready. mem_wlast=1 on the final word. On the final handshake, goes to RD_REQ.
- RD_REQ: mem_req_valid=1, write=0, addr={miss tag,index,0}. Goes to RD_DATA on mem_req_ready.
- RD_DATA: each mem_rvalid produces the same-cycle arr_we with arr_word=beat count and arr_wdata=mem_rdata.
  - The beat counter is authoritative. The line is complete after LINE_WORDS beats; next state DONE.
  - mem_rlast on a non-final beat, or absent on the final beat, sets proto_err (sticky until reset). No abort.
- DONE (1 cycle): tag_we=1 with the latched way/index/miss tag; lru_enable=1, lru_target=way; refill_done=1. Next state IDLE.
- Latency, clean victim with zero-wait memory: accept -> RD_REQ 1 cycle -> LINE_WORDS beats -> DONE.
- Fill order is always word 0 first (no critical-word-first).
- Victim with victim_valid=0 is never written back, regardless of victim_dirty.
- Counters wrap only via explicit reset to 0 on state entry.

Decomposition:
- Shared cache package holds: the state enum (IDLE, WB_BUF, WB_REQ, WB_DATA, RD_REQ, RD_DATA, DONE), the OFFSET_W/TAG_W derivation functions, and the line-address construction helper.
- One sub-module is natural: refill_line_buf, a LINE_WORDS x DATA_W victim buffer with a write port and an indexed read port.

Test Plan:
- Clean miss: victim_valid=1, dirty=0, addr 0x0000_1230, lru_replace=1, zero-wait memory -> one read request at addr 0x0000_1230. Four arr_we on way 1, words 0..3. tag_we way 1. lru_enable with target=1, same cycle as refill_done. No write request.
- Dirty miss: dirty=1, victim_tag=0x1ABCD -> 4 arr_re, then a write request at {0x1ABCD,index,0}. 4 wbeats matching array data, wlast on beat 3. Then the read refill follows.
- Backpressure: mem_req_ready low for 5 cycles and mem_wready toggling -> request and write fields stable while stalled. No lost or duplicated beat.
- rlast protocol: rlast asserted on beat 1 -> proto_err=1 and remains 1. Fill still completes 4 beats.
- Reset mid-WB_DATA -> all outputs 0, miss_ready=1 immediately. A new miss then completes normally.
- miss_valid held during a refill -> miss_ready=0 until the cycle after DONE. The second miss is accepted exactly once.
